// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the load-data extension helper.
package mem_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Extend a byte (half=0) or halfword (half=1) to 32 bits, signed or not.
    function automatic logic [31:0] ext_load(input logic [15:0] v,
                                             input logic        half,
                                             input logic        sgn);
        logic [31:0] r;
        if (half) begin
            r = sgn ? {{16{v[15]}}, v} : {16'h0000, v};
        end else begin
            r = sgn ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/acknowledge data bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_be_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_ack_i;
    logic [31:0]       bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Lane steering for the LSU: byte enables, store lane replication,
// load byte/half selection with extension, and alignment checking.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
    assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode the access size into lanes, extended load data and alignment.
    always_comb begin
        be       = 4'b0000;
        wdata    = 32'h0000_0000;
        ldata    = 32'h0000_0000;
        misalign = 1'b0;
        case (op)
            LSU_B, LSU_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = ext_load({8'h00, byte_s}, 1'b0, (op == LSU_B));
            end
            LSU_H, LSU_HU: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                ldata    = ext_load(half_s, 1'b1, (op == LSU_H));
            end
            LSU_W: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
                wdata    = sdata;
                ldata    = rdata;
            end
            default: begin
                // Unknown funct3 is rejected the same way as a misaligned access.
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle memory stage: issues one bus access per load/store, stalls the
// pipeline until ack or timeout, then presents the write-back result.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic                  mem_ce_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_sdata_i,
    input  logic                  stall_i,
    mem_lsu_if.master             bus,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stallreq,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    lsu_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [31:0]       rdata_r, rdata_nxt_s;
    logic              err_r, err_nxt_s;
    logic              req_r, req_nxt_s;

    logic [3:0]        be_s;
    logic [31:0]       lane_wdata_s;
    logic [31:0]       ldata_s;
    logic              mis_s;

    // Loads extend the captured word, so alignment always sees rdata_r.
    mem_lsu_align u_align (
        .op       (mem_op_i),
        .addr_lo  (mem_addr_i[1:0]),
        .sdata    (mem_sdata_i),
        .rdata    (rdata_r),
        .be       (be_s),
        .wdata    (lane_wdata_s),
        .ldata    (ldata_s),
        .misalign (mis_s)
    );

    // State, counter, capture, error and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rdata_r <= rdata_nxt_s;
            err_r   <= err_nxt_s;
            req_r   <= req_nxt_s;
        end
    end

    // Next-state logic: launch, wait for ack or timeout, then hand off.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rdata_nxt_s = rdata_r;
        err_nxt_s   = err_r;
        req_nxt_s   = req_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                err_nxt_s = 1'b0;
                if (mem_ce_i && !mis_s) begin
                    state_nxt_s = ST_WAIT;
                    req_nxt_s   = 1'b1;
                end else begin
                    req_nxt_s   = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                if (bus.bus_ack_i) begin
                    // Ack has priority over a timeout landing in the same cycle.
                    rdata_nxt_s = bus.bus_rdata_i;
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
                    err_nxt_s   = 1'b1;
                    req_nxt_s   = 1'b0;
                    state_nxt_s = ST_DONE;
                end else begin
                    req_nxt_s   = 1'b1;
                end
            end
            ST_DONE: begin
                req_nxt_s = 1'b0;
                if (!stall_i) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
                err_nxt_s   = 1'b0;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // Pipeline-facing outputs; everything reads zero while reset is held.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = 32'h0000_0000;
        stallreq   = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        if (rst) begin
            wreg_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    if (!mem_ce_i) begin
                        wreg_o = wreg_i;
                    end else if (mis_s) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                ST_WAIT: begin
                    wd_o     = wd_i;
                    wdata_o  = wdata_i;
                    stallreq = 1'b1;
                end
                ST_DONE: begin
                    wd_o = wd_i;
                    if (err_r) begin
                        bus_err_o = 1'b1;
                        wdata_o   = wdata_i;
                    end else if (mem_we_i) begin
                        wdata_o   = wdata_i;
                    end else begin
                        wreg_o  = wreg_i;
                        wdata_o = ldata_s;
                    end
                end
                default: begin
                    wd_o = '0;
                end
            endcase
        end
    end

    // Bus drive: fields are only non-zero while a request is outstanding.
    always_comb begin
        bus.bus_req_o   = 1'b0;
        bus.bus_we_o    = 1'b0;
        bus.bus_addr_o  = '0;
        bus.bus_be_o    = 4'b0000;
        bus.bus_wdata_o = 32'h0000_0000;
        if (!rst && req_r) begin
            bus.bus_req_o   = 1'b1;
            bus.bus_we_o    = mem_we_i;
            bus.bus_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
            bus.bus_be_o    = be_s;
            bus.bus_wdata_o = lane_wdata_s;
        end else begin
            bus.bus_req_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus queues expected bus requests and
// write-back results; a negedge monitor pops and compares them.
module tb_mem_lsu;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_data;
        logic        mis;
        logic        err;
        int          stall_cyc;
        int          req_cyc;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        stall_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        misalign_o;
    logic        bus_err_o;

    mem_lsu_if #(.ADDR_W(32)) bus_if ();

    mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .stall_i     (stall_i),
        .bus         (bus_if),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq    (stallreq),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o)
    );

    res_t res_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stim_to = 0;
    bit   stim_done = 0;
    bit   final_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_res(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic chk_data, input logic mis, input logic err,
                            input int st, input int rq);
        res_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk_data;
        e.mis = mis; e.err = err; e.stall_cyc = st; e.req_cyc = rq;
        res_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    // One memory access; ack_at = WAIT cycle that acks (0 = never).
    task automatic do_op(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] wd, input int ack_at, input int stall_n);
        int  k;
        bit  done;
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = we; mem_op_i = op; mem_addr_i = addr;
        mem_sdata_i = sdata; wd_i = wd; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA;
        bus_if.bus_rdata_i = rdata;
        k = 0;
        done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (!stallreq) begin
                done = 1'b1;
            end else if (bus_if.bus_req_o) begin
                k++;
                bus_if.bus_ack_i = (k == ack_at);
            end
        end
        if (!done) begin
            stim_to++;
            $display("FAIL op_budget: stallreq still %0b after 64 cycles, required 0", stallreq);
        end
        bus_if.bus_ack_i = 1'b0;
        if (stall_n > 0) begin
            stall_i = 1'b1;
            repeat (stall_n) @(posedge clk);
            #1 stall_i = 1'b0;
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0; wreg_i = 1'b0; mem_we_i = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: reset zeros, bus request fields, write-back results, idle quiet.
    always @(negedge clk) begin : monitor
        static int   stall_cnt = 0;
        static int   req_cnt = 0;
        static logic prev_req = 1'b0;
        res_t e;
        bus_t b;
        if (rst) begin
            chk("rst_ctl", 32'({wd_o, wreg_o, stallreq, misalign_o, bus_err_o,
                                bus_if.bus_req_o, bus_if.bus_we_o, bus_if.bus_be_o}), 32'h0);
            chk("rst_wdata", wdata_o, 32'h0);
            chk("rst_bus", bus_if.bus_addr_o | bus_if.bus_wdata_o, 32'h0);
            stall_cnt = 0;
            req_cnt = 0;
            prev_req = 1'b0;
        end else begin
            if (stallreq) stall_cnt++;
            if (bus_if.bus_req_o && !prev_req) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", 32'(bus_if.bus_req_o), 32'h0);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(bus_if.bus_we_o), 32'(b.we));
                    chk("bus_addr", bus_if.bus_addr_o, b.addr);
                    chk("bus_be", 32'(bus_if.bus_be_o), 32'(b.be));
                    chk("bus_wdata", bus_if.bus_wdata_o, b.wdata);
                end
            end
            if (bus_if.bus_req_o) req_cnt++;
            prev_req = bus_if.bus_req_o;
            if ((mem_ce_i && !stallreq) || (!mem_ce_i && wreg_o)) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", 32'(wreg_o), 32'h0);
                end else begin
                    e = res_q.pop_front();
                    chk("res_wd", 32'(wd_o), 32'(e.wd));
                    chk("res_wreg", 32'(wreg_o), 32'(e.wreg));
                    if (e.chk_data) chk("res_wdata", wdata_o, e.wdata);
                    chk("res_misalign", 32'(misalign_o), 32'(e.mis));
                    chk("res_bus_err", 32'(bus_err_o), 32'(e.err));
                    chk("res_stall_cycles", 32'(stall_cnt), 32'(e.stall_cyc));
                    chk("res_req_cycles", 32'(req_cnt), 32'(e.req_cyc));
                end
                stall_cnt = 0;
                req_cnt = 0;
            end else if (!mem_ce_i) begin
                chk("idle_quiet", 32'({stallreq, misalign_o, bus_err_o}), 32'h0);
            end
            if (stim_done && !final_done) begin
                chk("leftover_res", 32'(res_q.size()), 32'h0);
                chk("leftover_bus", 32'(bus_q.size()), 32'h0);
                chk("stim_timeouts", 32'(stim_to), 32'h0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; mem_ce_i = 1'b0;
        mem_we_i = 1'b0; mem_op_i = 3'b000; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
        stall_i = 1'b0; bus_if.bus_ack_i = 1'b0; bus_if.bus_rdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Passthrough with no memory access
        @(posedge clk); #1;
        push_res(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 0, 0);
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h0000_1234;
        @(posedge clk); #1 wreg_i = 1'b0;

        // LB lane 3, ack in first WAIT cycle
        push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
        push_res(5'd1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 2, 1);
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 5'd1, 1, 0);

        // SH upper half, ack on third WAIT cycle
        push_bus(1'b1, 32'h200, 4'b1100, 32'h5678_5678);
        push_res(5'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4, 3);
        do_op(1'b1, 3'b001, 32'h202, 32'hABCD_5678, 32'h0, 5'd2, 3, 0);

        // Misaligned LW and invalid funct3
        push_res(5'd7, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd7, 1, 0);
        push_res(5'd6, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd6, 1, 0);

        // LHU with no ack: 16 request cycles then bus error
        push_bus(1'b0, 32'h10C, 4'b1100, 32'h0);
        push_res(5'd8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 17, 16);
        do_op(1'b0, 3'b101, 32'h10E, 32'h0, 32'h0, 5'd8, 0, 0);

        // LW held in DONE for two extra cycles
        push_bus(1'b0, 32'h104, 4'b1111, 32'h0);
        push_res(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 3, 2);
        push_res(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0, 0);
        push_res(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0, 0);
        do_op(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 5'd9, 2, 2);

        // Reset in the middle of WAIT, then a late ack while idle
        push_bus(1'b0, 32'h108, 4'b1111, 32'h0);
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_op_i = 3'b010; mem_addr_i = 32'h108;
        mem_sdata_i = 32'h0; wd_i = 5'd3; wreg_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; mem_ce_i = 1'b0; wreg_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hBADB_AD00;
        @(negedge clk);
        bus_if.bus_ack_i = 1'b0;

        // Remaining sizes and lanes
        push_bus(1'b0, 32'h108, 4'b0100, 32'h0);
        push_res(5'd10, 1'b1, 32'h0000_00F2, 1'b1, 1'b0, 1'b0, 2, 1);
        do_op(1'b0, 3'b100, 32'h10A, 32'h0, 32'h00F2_0000, 5'd10, 1, 0);

        push_bus(1'b0, 32'h104, 4'b1100, 32'h0);
        push_res(5'd11, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 3, 2);
        do_op(1'b0, 3'b001, 32'h106, 32'h0, 32'h8001_0000, 5'd11, 2, 0);

        push_bus(1'b0, 32'h100, 4'b1100, 32'h0);
        push_res(5'd14, 1'b1, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 2, 1);
        do_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 5'd14, 1, 0);

        push_bus(1'b1, 32'h300, 4'b0010, 32'h4444_4444);
        push_res(5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        do_op(1'b1, 3'b000, 32'h301, 32'h1122_3344, 32'h0, 5'd12, 1, 0);

        push_bus(1'b1, 32'h300, 4'b1111, 32'hCAFE_F00D);
        push_res(5'd13, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1);
        do_op(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 5'd13, 1, 0);

        repeat (2) @(posedge clk);
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
